miriscv_lsu_req_stage: RTL and testbench
========================================

MIRISCV_LSU_REQ_STAGE -- requirements
Module: miriscv_lsu_req_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk_i and arst_i.
REQ-002 Parameter XLEN, default 32: data path width; legal values are 32 and 64.
REQ-003 Parameter PAYLOAD_W, default 64: width of the sideband payload carried from E to M.
REQ-004 Parameter MAX_OUTST, default 2: maximum number of granted requests without a response; legal range 1..4.
REQ-005 clk_i  in  1  clock.
REQ-006 arst_i  in  1  async reset, active-high.
REQ-007 cu_kill_m_i  in  1  flush of the M stage.
REQ-008 cu_stall_m_i  in  1  hold of the M stage.
REQ-009 m_stall_req_o  out  1  stall request to the control unit.
REQ-010 e_valid_i, e_mem_req_i, e_mem_we_i  in  1 each  E-stage valid, memory request, write enable.
REQ-011 e_mem_size_i  in  MEM_ACCESS_W  access size.
REQ-012 e_mem_addr_i, e_mem_data_i  in  XLEN each  address and store data.
REQ-013 e_payload_i  in  PAYLOAD_W  opaque sideband (gpr, branch and result fields).
REQ-014 m_valid_o  out  1  M-stage valid.
REQ-015 m_payload_o  out  PAYLOAD_W  registered payload.
REQ-016 m_mem_req_o, m_misaligned_o  out  1 each  registered request flag and misalignment flag.
REQ-017 m_mem_size_o  out  MEM_ACCESS_W  registered access size.
REQ-018 m_mem_addr_o  out  OFFS_W=$clog2(XLEN/8)  registered address offset.
REQ-019 data_req_o  out  1, and data_gnt_i  in  1: request/grant handshake.
REQ-020 data_rvalid_i  in  1  response strobe, one per granted request.
REQ-021 data_we_o  out  1; data_be_o  out  XLEN/8; data_addr_o, data_wdata_o  out  XLEN.

Function
REQ-022 Define lsu_req = e_valid_i & e_mem_req_i & ~misaligned & ~cu_kill_m_i.
REQ-023 misaligned SHALL be asserted when the address offset is not a multiple of the access size (half: bit0; word: bits[1:0]; dword: bits[2:0]).
REQ-024 A DWORD access at XLEN=32 SHALL be treated as misaligned.
REQ-025 data_be_o SHALL be the size mask (1, 3, F, or FF lanes) shifted left by the offset; 0 on misaligned or unknown size.
REQ-026 data_wdata_o SHALL be e_mem_data_i rotated left by 8*offset bits.
REQ-027 data_addr_o and data_we_o SHALL equal e_mem_addr_i and e_mem_we_i.
REQ-028 data_req_o = lsu_req & (outst_cnt < MAX_OUTST).
REQ-029 Once data_req_o is asserted, it and all data_* outputs SHALL stay stable until data_gnt_i; this is held by stalling E.
REQ-030 FSM IDLE->WAIT_GNT on data_req_o & ~data_gnt_i; WAIT_GNT->IDLE on data_gnt_i or cu_kill_m_i.
REQ-031 m_stall_req_o = lsu_req & ~(data_req_o & data_gnt_i), i.e. stall on grant missing or counter full.
REQ-032 outst_cnt: +1 on data_req_o&data_gnt_i, -1 on data_rvalid_i, unchanged on both together. Kill SHALL NOT clear it, because granted responses still return.
REQ-033 An rvalid arriving with outst_cnt==0 SHALL be ignored (counter saturates at 0); the counter SHALL never exceed MAX_OUTST.
REQ-034 Pipeline register: m_valid_o <= 0 on kill; otherwise <= e_valid_i & ~m_stall_req_o when ~cu_stall_m_i; otherwise held.
REQ-035 Data fields (payload, req, size, offset, misaligned) SHALL load under the same enable as m_valid_o, gated by e_valid_i. They are not reset.
REQ-036 Latency: grant in the cycle of the request gives m_valid_o in the next cycle; each cycle of grant delay adds one cycle.

Reset
REQ-037 On arst_i: m_valid_o=0, FSM=IDLE, outst_cnt=0. Therefore data_req_o and m_stall_req_o follow inputs only.
REQ-038 Reset during WAIT_GNT SHALL abandon the request; no response is expected afterwards.

Structure
REQ-039 MEM_ACCESS_* encodings (adding MEM_ACCESS_DWORD) and the state typedef SHALL live in miriscv_lsu_pkg.
REQ-040 Byte-enable and rotate logic SHALL be a sub-module, miriscv_lsu_store_align, parametrised by XLEN.

Verification
REQ-041 XLEN=32, SW to addr 0x1002 -> misaligned=1, data_req_o=0, m_misaligned_o=1 next cycle.
REQ-042 SB data 0x000000AB to addr 0x3 -> data_be_o=1000, data_wdata_o=0xAB000000.
REQ-043 data_gnt_i delayed 3 cycles -> m_stall_req_o high 3 cycles, data_* stable, m_valid_o=1 once.
REQ-044 MAX_OUTST=2, three back-to-back loads, no rvalid -> third held with stall; rvalid releases it.
REQ-045 Grant and rvalid in the same cycle with cnt=1 -> cnt stays 1.
REQ-046 Kill during WAIT_GNT -> data_req_o=0 same cycle, FSM=IDLE, m_valid_o=0.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared LSU definitions: memory access size encodings and the request FSM state type.
package miriscv_lsu_pkg;

  localparam int MEM_ACCESS_W = 3;

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'b000;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'b001;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'b010;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DWORD = 3'b011;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'b100;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'b101;

  typedef enum logic {
    LSU_IDLE     = 1'b0,
    LSU_WAIT_GNT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/miriscv_lsu_req_stage_if.sv
// Data memory request bus between the LSU request stage and the memory side.
interface miriscv_lsu_req_stage_if #(
  parameter int XLEN = 32
);

  // Handshake: data_req is raised with all data_* fields valid and holds them
  // unchanged until the cycle data_gnt is seen high; each granted request is
  // answered later by exactly one data_rvalid pulse, in order.
  logic                data_req;
  logic                data_gnt;
  logic                data_rvalid;
  logic                data_we;
  logic [XLEN/8-1:0]   data_be;
  logic [XLEN-1:0]     data_addr;
  logic [XLEN-1:0]     data_wdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid
  );

endinterface

// File: rtl/miriscv_lsu_store_align.sv
// Store lane alignment: misalignment detection, byte enables and store-data rotation.
module miriscv_lsu_store_align
  import miriscv_lsu_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int NB     = XLEN / 8,
  localparam int OFFS_W = $clog2(NB)
) (
  input  logic [MEM_ACCESS_W-1:0] size,
  input  logic [OFFS_W-1:0]       offset,
  input  logic [XLEN-1:0]         data,
  output logic                    misaligned,
  output logic [NB-1:0]           be,
  output logic [XLEN-1:0]         wdata
);

  logic [NB-1:0]     lane_mask;
  logic [2*XLEN-1:0] rot;

  always_comb begin
    lane_mask  = '0;
    misaligned = 1'b0;
    case (size)
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: begin
        lane_mask = NB'(1);
      end
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: begin
        lane_mask  = NB'(3);
        misaligned = offset[0];
      end
      MEM_ACCESS_WORD: begin
        lane_mask  = NB'(4'hF);
        misaligned = |offset[1:0];
      end
      MEM_ACCESS_DWORD: begin
        lane_mask  = NB'(8'hFF);
        // A 32-bit data path cannot carry a doubleword in one beat.
        misaligned = (XLEN == 32) ? 1'b1 : |offset;
      end
      default: begin
        lane_mask  = '0;
        misaligned = 1'b0;
      end
    endcase
  end

  assign be    = misaligned ? '0 : (lane_mask << offset);
  assign rot   = {data, data} << {offset, 3'b000};
  assign wdata = rot[2*XLEN-1:XLEN];

endmodule

// File: rtl/miriscv_lsu_req_stage.sv
// LSU request stage: issues data memory requests from E, tracks outstanding
// responses and registers the E->M pipeline fields.
module miriscv_lsu_req_stage
  import miriscv_lsu_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int PAYLOAD_W = 64,
  parameter  int MAX_OUTST = 2,
  localparam int OFFS_W    = $clog2(XLEN / 8),
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                    clk_i,
  input  logic                    arst_i,

  input  logic                    cu_kill_m_i,
  input  logic                    cu_stall_m_i,
  output logic                    m_stall_req_o,

  input  logic                    e_valid_i,
  input  logic                    e_mem_req_i,
  input  logic                    e_mem_we_i,
  input  logic [MEM_ACCESS_W-1:0] e_mem_size_i,
  input  logic [XLEN-1:0]         e_mem_addr_i,
  input  logic [XLEN-1:0]         e_mem_data_i,
  input  logic [PAYLOAD_W-1:0]    e_payload_i,

  output logic                    m_valid_o,
  output logic [PAYLOAD_W-1:0]    m_payload_o,
  output logic                    m_mem_req_o,
  output logic                    m_misaligned_o,
  output logic [MEM_ACCESS_W-1:0] m_mem_size_o,
  output logic [OFFS_W-1:0]       m_mem_addr_o,

  miriscv_lsu_req_stage_if.master data_if,

  output lsu_state_e              dbg_state_o,
  output logic [CNT_W-1:0]        dbg_outst_cnt_o
);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  outst_cnt;
  logic              misaligned;
  logic              lsu_req;
  logic              data_req;
  logic              accept;
  logic              rsp;
  logic              data_en;

  miriscv_lsu_store_align #(.XLEN(XLEN)) u_store_align (
    .size       (e_mem_size_i),
    .offset     (e_mem_addr_i[OFFS_W-1:0]),
    .data       (e_mem_data_i),
    .misaligned (misaligned),
    .be         (data_if.data_be),
    .wdata      (data_if.data_wdata)
  );

  assign lsu_req  = e_valid_i & e_mem_req_i & ~misaligned & ~cu_kill_m_i;
  assign data_req = lsu_req & (outst_cnt < CNT_W'(MAX_OUTST));
  assign accept   = data_req & data_if.data_gnt;
  // Responses with nothing outstanding are stray and must not underflow.
  assign rsp      = data_if.data_rvalid & (outst_cnt != '0);

  assign data_if.data_req  = data_req;
  assign data_if.data_addr = e_mem_addr_i;
  assign data_if.data_we   = e_mem_we_i;

  // E is held while the request is not yet granted, which keeps data_* stable.
  assign m_stall_req_o = lsu_req & ~accept;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:     if (data_req && !data_if.data_gnt)         state_d = LSU_WAIT_GNT;
      LSU_WAIT_GNT: if (data_if.data_gnt || cu_kill_m_i)        state_d = LSU_IDLE;
      default:                                                  state_d = LSU_IDLE;
    endcase
  end

  // A kill leaves the count alone: already granted responses still arrive.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      outst_cnt <= '0;
    end else begin
      case ({accept, rsp})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      m_valid_o <= 1'b0;
    end else if (cu_kill_m_i) begin
      m_valid_o <= 1'b0;
    end else if (!cu_stall_m_i) begin
      m_valid_o <= e_valid_i & ~m_stall_req_o;
    end
  end

  assign data_en = ~cu_kill_m_i & ~cu_stall_m_i & e_valid_i;

  always_ff @(posedge clk_i) begin
    if (data_en) begin
      m_payload_o    <= e_payload_i;
      m_mem_req_o    <= e_mem_req_i;
      m_mem_size_o   <= e_mem_size_i;
      m_mem_addr_o   <= e_mem_addr_i[OFFS_W-1:0];
      m_misaligned_o <= misaligned;
    end
  end

  assign dbg_state_o     = state_q;
  assign dbg_outst_cnt_o = outst_cnt;

endmodule

// File: tb/tb_miriscv_lsu_req_stage.sv
// Bench for miriscv_lsu_req_stage: directed vectors, a behavioural reference
// model compared every cycle, and literal checks on the key scenarios.
module tb_miriscv_lsu_req_stage;
  import miriscv_lsu_pkg::*;

  localparam int XLEN      = 32;
  localparam int PAYLOAD_W = 64;
  localparam int MAX_OUTST = 2;
  localparam int OFFS_W    = 2;
  localparam int CNT_W     = 2;
  localparam int W         = PAYLOAD_W + 1 + MEM_ACCESS_W + OFFS_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_i;
  always #5 clk = ~clk;

  logic                    cu_kill_m_i, cu_stall_m_i, m_stall_req_o;
  logic                    e_valid_i, e_mem_req_i, e_mem_we_i;
  logic [MEM_ACCESS_W-1:0] e_mem_size_i;
  logic [XLEN-1:0]         e_mem_addr_i, e_mem_data_i;
  logic [PAYLOAD_W-1:0]    e_payload_i;
  logic                    m_valid_o, m_mem_req_o, m_misaligned_o;
  logic [PAYLOAD_W-1:0]    m_payload_o;
  logic [MEM_ACCESS_W-1:0] m_mem_size_o;
  logic [OFFS_W-1:0]       m_mem_addr_o;
  lsu_state_e              dbg_state;
  logic [CNT_W-1:0]        dbg_cnt;

  miriscv_lsu_req_stage_if #(.XLEN(XLEN)) data_if ();

  miriscv_lsu_req_stage #(
    .XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst_i),
    .cu_kill_m_i     (cu_kill_m_i),
    .cu_stall_m_i    (cu_stall_m_i),
    .m_stall_req_o   (m_stall_req_o),
    .e_valid_i       (e_valid_i),
    .e_mem_req_i     (e_mem_req_i),
    .e_mem_we_i      (e_mem_we_i),
    .e_mem_size_i    (e_mem_size_i),
    .e_mem_addr_i    (e_mem_addr_i),
    .e_mem_data_i    (e_mem_data_i),
    .e_payload_i     (e_payload_i),
    .m_valid_o       (m_valid_o),
    .m_payload_o     (m_payload_o),
    .m_mem_req_o     (m_mem_req_o),
    .m_misaligned_o  (m_misaligned_o),
    .m_mem_size_o    (m_mem_size_o),
    .m_mem_addr_o    (m_mem_addr_o),
    .data_if         (data_if.master),
    .dbg_state_o     (dbg_state),
    .dbg_outst_cnt_o (dbg_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int pay_n = 0;
  int mv_seen;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_pack;

  assign dut_pack = {m_payload_o, m_mem_req_o, m_mem_size_o, m_mem_addr_o, m_misaligned_o};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [MEM_ACCESS_W-1:0] s);
    case (s)
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: return 1;
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: return 2;
      MEM_ACCESS_WORD:                   return 4;
      MEM_ACCESS_DWORD:                  return 8;
      default:                           return 0;
    endcase
  endfunction

  function automatic bit model_mis(input logic [MEM_ACCESS_W-1:0] s, input logic [XLEN-1:0] a);
    int b;
    b = size_bytes(s);
    if (b == 0) return 1'b0;
    if (b > XLEN / 8) return 1'b1;
    return (a % b) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [MEM_ACCESS_W-1:0] s, input logic [XLEN-1:0] a);
    int b;
    logic [7:0] m;
    b = size_bytes(s);
    if (b == 0 || model_mis(s, a)) return 4'h0;
    m = 8'((1 << b) - 1);
    return 4'(m << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [XLEN-1:0] a);
    longint unsigned v;
    v = 64'(d);
    v = v << (8 * (a % 4));
    return v[31:0] | v[63:32];
  endfunction

  int mdl_cnt;
  bit mdl_wait;
  bit mdl_mvalid;

  always @(negedge clk) begin : cmp
    bit mis, lreq, req, gnt, rv, acc, stall;
    if (arst_i) begin
      mdl_cnt    = 0;
      mdl_wait   = 1'b0;
      mdl_mvalid = 1'b0;
      exp_q.delete();
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_state", dbg_state, LSU_IDLE);
      chk("rst_cnt", dbg_cnt, 0);
    end else begin
      mis   = model_mis(e_mem_size_i, e_mem_addr_i);
      lreq  = e_valid_i && e_mem_req_i && !mis && !cu_kill_m_i;
      req   = lreq && (mdl_cnt < MAX_OUTST);
      gnt   = data_if.data_gnt;
      rv    = data_if.data_rvalid;
      acc   = req && gnt;
      stall = lreq && !acc;

      chk("data_req", data_if.data_req, req);
      chk("m_stall_req", m_stall_req_o, stall);
      chk("data_be", data_if.data_be, model_be(e_mem_size_i, e_mem_addr_i));
      chk("data_wdata", data_if.data_wdata, model_wdata(e_mem_data_i, e_mem_addr_i));
      chk("data_addr", data_if.data_addr, e_mem_addr_i);
      chk("data_we", data_if.data_we, e_mem_we_i);
      chk("m_valid", m_valid_o, mdl_mvalid);
      chk("state", dbg_state, mdl_wait ? LSU_WAIT_GNT : LSU_IDLE);
      chk("outst_cnt", dbg_cnt, mdl_cnt);

      if (m_valid_o) begin
        chk("m_fields_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("m_fields", dut_pack, exp_q[0]);
          if (cu_kill_m_i || !cu_stall_m_i) void'(exp_q.pop_front());
        end
      end

      if (acc && !(rv && mdl_cnt > 0)) mdl_cnt = mdl_cnt + 1;
      else if (!acc && rv && mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
      mdl_wait = mdl_wait ? !(gnt || cu_kill_m_i) : (req && !gnt);
      if (cu_kill_m_i) mdl_mvalid = 1'b0;
      else if (!cu_stall_m_i) mdl_mvalid = e_valid_i && !stall;
      if (!cu_kill_m_i && !cu_stall_m_i && e_valid_i && !stall)
        exp_q.push_back({e_payload_i, e_mem_req_i, e_mem_size_i, 2'(e_mem_addr_i % 4), mis});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input logic we, input logic [MEM_ACCESS_W-1:0] sz,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    pay_n++;
    e_valid_i    = v;
    e_mem_req_i  = v;
    e_mem_we_i   = we;
    e_mem_size_i = sz;
    e_mem_addr_i = a;
    e_mem_data_i = d;
    e_payload_i  = {32'hC0DE_0000 + 32'(pay_n), a};
  endtask

  task automatic set_idle();
    set_e(1'b0, 1'b0, MEM_ACCESS_BYTE, '0, '0);
  endtask

  typedef struct {
    logic [MEM_ACCESS_W-1:0] sz;
    logic [XLEN-1:0]         a;
    logic [XLEN-1:0]         d;
  } vec_t;

  vec_t vecs[8];

  // ---------------- directed sequence ----------------
  initial begin
    vecs[0] = '{MEM_ACCESS_HALF,  32'h0000_0002, 32'h0000_1234};
    vecs[1] = '{MEM_ACCESS_HALF,  32'h0000_0005, 32'h0000_5678};
    vecs[2] = '{MEM_ACCESS_BYTE,  32'h0000_0001, 32'h0000_00CD};
    vecs[3] = '{MEM_ACCESS_DWORD, 32'h0000_0008, 32'h1111_2222};
    vecs[4] = '{MEM_ACCESS_UHALF, 32'h0000_0006, 32'h0000_BEEF};
    vecs[5] = '{MEM_ACCESS_WORD,  32'h0000_0010, 32'hDEAD_BEEF};
    vecs[6] = '{3'b110,           32'h0000_0020, 32'h0102_0304};
    vecs[7] = '{MEM_ACCESS_UBYTE, 32'h0000_0023, 32'h0000_0077};

    arst_i = 1'b1;
    cu_kill_m_i = 1'b0;
    cu_stall_m_i = 1'b0;
    data_if.data_gnt = 1'b0;
    data_if.data_rvalid = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0;
    tick();

    // Misaligned word store never reaches the bus but still moves to M.
    set_e(1'b1, 1'b1, MEM_ACCESS_WORD, 32'h0000_1002, 32'h1234_5678);
    data_if.data_gnt = 1'b1;
    #1;
    chk("sw_mis_data_req", data_if.data_req, 0);
    chk("sw_mis_be", data_if.data_be, 0);
    chk("sw_mis_stall", m_stall_req_o, 0);
    tick();
    chk("sw_mis_m_misaligned", m_misaligned_o, 1);
    chk("sw_mis_m_valid", m_valid_o, 1);

    // Byte store to offset 3.
    set_e(1'b1, 1'b1, MEM_ACCESS_BYTE, 32'h0000_0003, 32'h0000_00AB);
    #1;
    chk("sb_be", data_if.data_be, 4'b1000);
    chk("sb_wdata", data_if.data_wdata, 32'hAB00_0000);
    chk("sb_data_req", data_if.data_req, 1);
    tick();
    chk("sb_cnt", dbg_cnt, 1);
    set_idle();
    data_if.data_gnt = 1'b0;
    data_if.data_rvalid = 1'b1;
    tick();
    chk("sb_drain_cnt", dbg_cnt, 0);

    // Stray response with nothing outstanding.
    tick();
    data_if.data_rvalid = 1'b0;
    chk("stray_rvalid_cnt", dbg_cnt, 0);

    // Grant delayed by three cycles.
    mv_seen = 0;
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gnt_wait_stall", m_stall_req_o, 1);
      chk("gnt_wait_req", data_if.data_req, 1);
      chk("gnt_wait_addr", data_if.data_addr, 32'h0000_0100);
      chk("gnt_wait_be", data_if.data_be, 4'hF);
      tick();
      chk("gnt_wait_state", dbg_state, LSU_WAIT_GNT);
      mv_seen += int'(m_valid_o);
    end
    data_if.data_gnt = 1'b1;
    #1;
    chk("gnt_now_stall", m_stall_req_o, 0);
    tick();
    chk("gnt_m_valid", m_valid_o, 1);
    mv_seen += int'(m_valid_o);
    set_idle();
    data_if.data_gnt = 1'b0;
    tick();
    mv_seen += int'(m_valid_o);
    chk("gnt_m_valid_once", mv_seen, 1);
    data_if.data_rvalid = 1'b1;
    tick();
    data_if.data_rvalid = 1'b0;

    // Three back-to-back loads against a limit of two outstanding.
    data_if.data_gnt = 1'b1;
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0200, 32'h0);
    tick();
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0204, 32'h0);
    tick();
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0208, 32'h0);
    #1;
    chk("full_cnt", dbg_cnt, 2);
    chk("full_data_req", data_if.data_req, 0);
    chk("full_stall", m_stall_req_o, 1);
    tick();
    data_if.data_rvalid = 1'b1;
    #1;
    chk("full_hold_stall", m_stall_req_o, 1);
    tick();
    data_if.data_rvalid = 1'b0;
    #1;
    chk("release_data_req", data_if.data_req, 1);
    chk("release_stall", m_stall_req_o, 0);
    tick();
    chk("release_cnt", dbg_cnt, 2);
    set_idle();
    data_if.data_gnt = 1'b0;
    data_if.data_rvalid = 1'b1;
    repeat (2) tick();
    data_if.data_rvalid = 1'b0;
    chk("full_drain_cnt", dbg_cnt, 0);

    // Grant and response in the same cycle with one outstanding.
    data_if.data_gnt = 1'b1;
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0300, 32'h0);
    tick();
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0304, 32'h0);
    data_if.data_rvalid = 1'b1;
    tick();
    data_if.data_rvalid = 1'b0;
    chk("gnt_rvalid_cnt", dbg_cnt, 1);
    set_idle();
    data_if.data_gnt = 1'b0;
    data_if.data_rvalid = 1'b1;
    tick();
    data_if.data_rvalid = 1'b0;

    // Kill while waiting for grant.
    set_e(1'b1, 1'b0, MEM_ACCESS_WORD, 32'h0000_0400, 32'h0);
    tick();
    chk("kill_pre_state", dbg_state, LSU_WAIT_GNT);
    cu_kill_m_i = 1'b1;
    #1;
    chk("kill_data_req", data_if.data_req, 0);
    chk("kill_stall", m_stall_req_o, 0);
    tick();
    cu_kill_m_i = 1'b0;
    chk("kill_state", dbg_state, LSU_IDLE);
    chk("kill_m_valid", m_valid_o, 0);
    chk("kill_cnt", dbg_cnt, 0);
    set_idle();
    tick();

    // Assorted sizes and offsets, with an M-stage hold in the middle.
    data_if.data_gnt = 1'b1;
    data_if.data_rvalid = 1'b1;
    set_e(1'b1, 1'b1, MEM_ACCESS_HALF, 32'h0000_0002, 32'h0000_1234);
    #1;
    chk("sh_be", data_if.data_be, 4'b1100);
    chk("sh_wdata", data_if.data_wdata, 32'h1234_0000);
    foreach (vecs[i]) begin
      set_e(1'b1, 1'(i % 2), vecs[i].sz, vecs[i].a, vecs[i].d);
      cu_stall_m_i = (i == 4 || i == 5);
      tick();
    end
    cu_stall_m_i = 1'b0;
    set_idle();
    repeat (4) tick();
    data_if.data_rvalid = 1'b0;
    data_if.data_gnt = 1'b0;
    tick();
    chk("end_cnt", dbg_cnt, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
